// File: rtl/car_game_pkg.sv
// car_game_pkg: shared widths, velocity type and button command encoding
package car_game_pkg;
   localparam int SCREEN_W = 640;
   localparam int CAR_W = 40;
   localparam int POS_W = 10;
   localparam int VEL_W = 5;
   typedef logic signed [VEL_W-1:0] vel_t;
   typedef enum logic [1:0] {CMD_NONE, CMD_LEFT, CMD_RIGHT} cmd_e;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus a frame-tick debounce counter
module btn_debounce #(
   parameter int DEB_FRAMES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic frame_tick,
   input  logic btn,
   output logic level
);
   logic [1:0] sync;
   logic [3:0] cnt;
   always_ff @(posedge clk) begin
      if (reset) begin
         sync  <= '0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         sync <= {sync[0], btn};
         if (frame_tick) begin
            if (sync[1] == level) cnt <= '0;
            else if (cnt + 4'd1 == 4'(DEB_FRAMES)) begin
               level <= ~level;
               cnt   <= '0;
            end else cnt <= cnt + 4'd1;
         end
      end
   end
endmodule

// File: rtl/car_motion_ctrl.sv
// car_motion_ctrl: debounced buttons drive a clamped per-frame velocity and car X position
module car_motion_ctrl
   import car_game_pkg::*;
#(
   parameter int X_INIT     = 100,
   parameter int X_MIN      = 0,
   parameter int X_MAX      = SCREEN_W - CAR_W,
   parameter int MAX_SPEED  = 4,
   parameter int DEB_FRAMES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_tick,
   input  logic             btn_left,
   input  logic             btn_right,
   output logic [POS_W-1:0] car_x,
   output vel_t             velocity,
   output logic             at_left,
   output logic             at_right
);
   localparam vel_t V_MAX = vel_t'(MAX_SPEED);
   localparam vel_t V_ONE = vel_t'(1);
   localparam vel_t V_ZERO = vel_t'(0);
   localparam logic signed [11:0] S_MIN = 12'(X_MIN);
   localparam logic signed [11:0] S_MAX = 12'(X_MAX);
   logic lvl_l, lvl_r;
   cmd_e cmd;
   vel_t vel_nx;
   logic signed [11:0] sum;
   btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb_l (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn(btn_left), .level(lvl_l)
   );
   btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb_r (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn(btn_right), .level(lvl_r)
   );
   always_comb begin
      cmd = (lvl_l && !lvl_r) ? CMD_LEFT : (lvl_r && !lvl_l) ? CMD_RIGHT : CMD_NONE;
      vel_nx = (cmd == CMD_RIGHT) ? ((velocity >= V_MAX) ? V_MAX : velocity + V_ONE)
             : (cmd == CMD_LEFT)  ? ((velocity <= -V_MAX) ? -V_MAX : velocity - V_ONE)
             : (velocity > V_ZERO) ? velocity - V_ONE
             : (velocity < V_ZERO) ? velocity + V_ONE : V_ZERO;
      sum = {2'b00, car_x} + {{(12-VEL_W){velocity[VEL_W-1]}}, velocity};
   end
   // position integrates the pre-tick velocity; a clamp stops the car dead
   always_ff @(posedge clk) begin
      if (reset) begin
         car_x    <= POS_W'(X_INIT);
         velocity <= V_ZERO;
      end else if (frame_tick) begin
         if (sum < S_MIN) begin
            car_x    <= POS_W'(X_MIN);
            velocity <= V_ZERO;
         end else if (sum > S_MAX) begin
            car_x    <= POS_W'(X_MAX);
            velocity <= V_ZERO;
         end else begin
            car_x    <= sum[POS_W-1:0];
            velocity <= vel_nx;
         end
      end
   end
   assign at_left  = car_x == POS_W'(X_MIN);
   assign at_right = car_x == POS_W'(X_MAX);
endmodule
